// File: rtl/reloj_pkg.sv
// Shared limits, month numbers and reset defaults for the binary time/date counter.
package reloj_pkg;

    localparam logic [7:0] SEG_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HORA_MAX = 8'd23;
    localparam logic [7:0] MES_MAX  = 8'd12;
    localparam logic [7:0] ANIO_MAX = 8'd99;

    localparam logic [7:0] ENE = 8'd1;
    localparam logic [7:0] FEB = 8'd2;
    localparam logic [7:0] MAR = 8'd3;
    localparam logic [7:0] ABR = 8'd4;
    localparam logic [7:0] MAY = 8'd5;
    localparam logic [7:0] JUN = 8'd6;
    localparam logic [7:0] JUL = 8'd7;
    localparam logic [7:0] AGO = 8'd8;
    localparam logic [7:0] SEP = 8'd9;
    localparam logic [7:0] OCT = 8'd10;
    localparam logic [7:0] NOV = 8'd11;
    localparam logic [7:0] DIC = 8'd12;

    localparam int ANIO_INI_DEF = 0;
    localparam int MES_INI_DEF  = 1;
    localparam int DIA_INI_DEF  = 1;

endpackage

// File: rtl/dias_del_mes.sv
// Days in a month for years 2000-2099 (every year divisible by 4 is leap).
// Purely combinational; out-of-range months report 31 and are screened by the caller.
module dias_del_mes
    import reloj_pkg::*;
(
    input  logic [7:0] mes,
    input  logic [7:0] anio,
    output logic [4:0] dias
);

    always_comb begin
        dias = 5'd31;
        case (mes)
            FEB:                dias = (anio % 8'd4 == 8'd0) ? 5'd29 : 5'd28;
            ABR, JUN, SEP, NOV: dias = 5'd30;
            default:            dias = 5'd31;
        endcase
    end

endmodule

// File: rtl/reloj_calendario_binario.sv
// Binary s/m/h/day/month/year counter advanced by a 1 Hz tick, with validated full load.
// One-cycle latency on tick/load; no backpressure, load wins over a same-cycle tick.
module reloj_calendario_binario
    import reloj_pkg::*;
#(
    parameter int ANIO_INI = ANIO_INI_DEF,
    parameter int MES_INI  = MES_INI_DEF,
    parameter int DIA_INI  = DIA_INI_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] s_in,
    input  logic [7:0] m_in,
    input  logic [7:0] h_in,
    input  logic [7:0] d_in,
    input  logic [7:0] me_in,
    input  logic [7:0] a_in,
    output logic [7:0] s,
    output logic [7:0] m,
    output logic [7:0] h,
    output logic [7:0] d,
    output logic [7:0] me,
    output logic [7:0] a,
    output logic       act,
    output logic       err
);

    logic [4:0] dias_cur;
    logic [4:0] dias_in;
    logic       load_ok;

    dias_del_mes u_dias_cur (.mes(me),    .anio(a),    .dias(dias_cur));
    dias_del_mes u_dias_in  (.mes(me_in), .anio(a_in), .dias(dias_in));

    always_comb begin
        load_ok = (s_in <= SEG_MAX) && (m_in <= MIN_MAX) && (h_in <= HORA_MAX) &&
                  (me_in >= ENE) && (me_in <= MES_MAX) && (a_in <= ANIO_MAX) &&
                  (d_in != 8'd0) && (d_in <= {3'b000, dias_in});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s   <= 8'd0;
            m   <= 8'd0;
            h   <= 8'd0;
            d   <= 8'(DIA_INI);
            me  <= 8'(MES_INI);
            a   <= 8'(ANIO_INI);
            act <= 1'b0;
            err <= 1'b0;
        end else begin
            act <= 1'b0;
            err <= 1'b0;
            if (load) begin
                // A rejected load still swallows a coincident tick.
                if (load_ok) begin
                    s   <= s_in;
                    m   <= m_in;
                    h   <= h_in;
                    d   <= d_in;
                    me  <= me_in;
                    a   <= a_in;
                    act <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end else if (tick) begin
                act <= 1'b1;
                if (s != SEG_MAX) begin
                    s <= s + 8'd1;
                end else begin
                    s <= 8'd0;
                    if (m != MIN_MAX) begin
                        m <= m + 8'd1;
                    end else begin
                        m <= 8'd0;
                        if (h != HORA_MAX) begin
                            h <= h + 8'd1;
                        end else begin
                            h <= 8'd0;
                            if (d < {3'b000, dias_cur}) begin
                                d <= d + 8'd1;
                            end else begin
                                d <= 8'd1;
                                if (me != MES_MAX) begin
                                    me <= me + 8'd1;
                                end else begin
                                    me <= ENE;
                                    a  <= (a == ANIO_MAX) ? 8'd0 : a + 8'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reloj_calendario_binario.sv
// Directed bench: calendar model compared every cycle, plus hand-computed spot checks.
module tb_reloj_calendario_binario;

    localparam int ANIO_INI = 0;
    localparam int MES_INI  = 1;
    localparam int DIA_INI  = 1;

    logic       clk = 1'b0;
    logic       reset, tick, load;
    logic [7:0] s_in, m_in, h_in, d_in, me_in, a_in;
    logic [7:0] s, m, h, d, me, a;
    logic       act, err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int act_total = 0;

    // Model state: time of day in seconds plus calendar date.
    int  t_sec, md, mme, ma;
    bit  mact, merr;

    always #5 clk = ~clk;

    reloj_calendario_binario #(.ANIO_INI(ANIO_INI), .MES_INI(MES_INI), .DIA_INI(DIA_INI)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .s_in(s_in), .m_in(m_in), .h_in(h_in), .d_in(d_in), .me_in(me_in), .a_in(a_in),
        .s(s), .m(m), .h(h), .d(d), .me(me), .a(a), .act(act), .err(err)
    );

    function automatic int month_len(int mes, int anio);
        int tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mes == 2 && (anio % 4) == 0) return 29;
        return tab[mes - 1];
    endfunction

    function automatic bit load_valid(int ss, int mi, int hh, int dd, int mo, int yy);
        if (ss > 59 || mi > 59 || hh > 23 || yy > 99) return 1'b0;
        if (mo < 1 || mo > 12) return 1'b0;
        return (dd >= 1) && (dd <= month_len(mo, yy));
    endfunction

    always @(posedge clk) begin
        mact = 1'b0;
        merr = 1'b0;
        if (reset) begin
            t_sec = 0; md = DIA_INI; mme = MES_INI; ma = ANIO_INI;
        end else if (load) begin
            if (load_valid(s_in, m_in, h_in, d_in, me_in, a_in)) begin
                t_sec = h_in * 3600 + m_in * 60 + s_in;
                md = d_in; mme = me_in; ma = a_in;
                mact = 1'b1;
            end else begin
                merr = 1'b1;
            end
        end else if (tick) begin
            mact = 1'b1;
            t_sec = t_sec + 1;
            if (t_sec == 86400) begin
                t_sec = 0;
                md = md + 1;
                if (md > month_len(mme, ma)) begin
                    md = 1;
                    mme = mme + 1;
                    if (mme > 12) begin
                        mme = 1;
                        ma = (ma + 1) % 100;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [49:0] got, exp;
        if (chk_en) begin
            got = {s, m, h, d, me, a, act, err};
            exp = {8'(t_sec / 3600), 8'((t_sec / 60) % 60), 8'(t_sec % 60), 8'(md), 8'(mme), 8'(ma), mact, merr};
            exp = {exp[33:26], exp[41:34], exp[49:42], exp[25:0]}; // reorder to s,m,h
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model t=%0t got s/m/h/d/me/a/act/err=%h required=%h", $time, got, exp);
            end
            if (act === 1'b1) act_total++;
        end
    end

    task automatic expect_out(string name, logic [47:0] f, logic ea, logic ee);
        checks++;
        if ({s, m, h, d, me, a} !== f || act !== ea || err !== ee) begin
            errors++;
            $display("FAIL %s got fields=%h act=%b err=%b required fields=%h act=%b err=%b",
                     name, {s, m, h, d, me, a}, act, err, f, ea, ee);
        end
    endtask

    task automatic apply(logic tk, logic ld, logic [7:0] vs, logic [7:0] vm, logic [7:0] vh,
                         logic [7:0] vd, logic [7:0] vme, logic [7:0] va);
        tick = tk; load = ld;
        s_in = vs; m_in = vm; h_in = vh; d_in = vd; me_in = vme; a_in = va;
        @(posedge clk); #1;
        tick = 1'b0; load = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        int act_before;
        reset = 1'b1; tick = 1'b0; load = 1'b0;
        s_in = '0; m_in = '0; h_in = '0; d_in = '0; me_in = '0; a_in = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_state", {8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0}, 1'b0, 1'b0);
        chk_en = 1'b1;
        reset = 1'b0;

        apply(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        expect_out("first_tick", {8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0}, 1'b1, 1'b0);
        idle();
        expect_out("act_one_cycle", {8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0}, 1'b0, 1'b0);

        apply(1'b0, 1'b1, 59, 59, 23, 31, 12, 99);
        expect_out("load_max", {8'd59, 8'd59, 8'd23, 8'd31, 8'd12, 8'd99}, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        expect_out("full_wrap", {8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0}, 1'b1, 1'b0);

        apply(1'b0, 1'b1, 59, 59, 23, 28, 2, 24);
        apply(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        expect_out("leap_feb29", {8'd0, 8'd0, 8'd0, 8'd29, 8'd2, 8'd24}, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        expect_out("leap_sec1", {8'd1, 8'd0, 8'd0, 8'd29, 8'd2, 8'd24}, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 59, 59, 23, 29, 2, 0);
        apply(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        expect_out("y2000_feb29_end", {8'd0, 8'd0, 8'd0, 8'd1, 8'd3, 8'd0}, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 59, 59, 23, 28, 2, 23);
        apply(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        expect_out("nonleap_mar1", {8'd0, 8'd0, 8'd0, 8'd1, 8'd3, 8'd23}, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 59, 59, 23, 30, 4, 50);
        apply(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        expect_out("apr30_may1", {8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd50}, 1'b1, 1'b0);

        apply(1'b0, 1'b1, 0, 0, 0, 31, 4, 50);
        expect_out("bad_apr31", {8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd50}, 1'b0, 1'b1);
        idle();
        expect_out("err_one_cycle", {8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd50}, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 0, 0, 0, 29, 2, 1);
        expect_out("bad_feb29", {8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd50}, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 60, 0, 0, 1, 1, 1);
        expect_out("bad_sec60", {8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd50}, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 0, 0, 24, 1, 1, 1);
        expect_out("bad_hour24", {8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd50}, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 0, 0, 0, 0, 1, 1);
        expect_out("bad_day0", {8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd50}, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 0, 0, 0, 1, 13, 1);
        expect_out("bad_month13", {8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd50}, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 0, 0, 0, 1, 1, 100);
        expect_out("bad_year100", {8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd50}, 1'b0, 1'b1);

        apply(1'b1, 1'b1, 10, 20, 5, 15, 6, 30);
        expect_out("load_tick_ok", {8'd10, 8'd20, 8'd5, 8'd15, 8'd6, 8'd30}, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 10, 20, 5, 31, 6, 30);
        expect_out("load_tick_bad", {8'd10, 8'd20, 8'd5, 8'd15, 8'd6, 8'd30}, 1'b0, 1'b1);
        idle();
        expect_out("hold_idle", {8'd10, 8'd20, 8'd5, 8'd15, 8'd6, 8'd30}, 1'b0, 1'b0);

        reset = 1'b1;
        apply(1'b1, 1'b1, 10, 20, 5, 15, 6, 30);
        reset = 1'b0;
        expect_out("reset_wins", {8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0}, 1'b0, 1'b0);

        act_before = act_total;
        tick = 1'b1;
        repeat (3600) @(posedge clk);
        #1;
        tick = 1'b0;
        expect_out("hour_run", {8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0}, 1'b1, 1'b0);
        idle();
        @(negedge clk); #1;
        checks++;
        if (act_total - act_before != 3600) begin
            errors++;
            $display("FAIL act_count got %0d required 3600", act_total - act_before);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
